// File: rtl/aes_ctr_ctrl.sv
//=============================================================================
// Module   : aes_ctr_ctrl
// Purpose  : CTR-mode sequencer in front of an AES encipher round stage.
//            Owns the 128-bit counter block, fires a one-cycle start pulse
//            into the encipher stage, XORs the returned keystream block with
//            the accepted data word and presents the result on a
//            valid/ready output. One block in flight at a time.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
// Parameters
//   CTR_WIDTH        : low counter bits that increment (8..128); the upper
//                      128-CTR_WIDTH bits are a fixed nonce.
// Ports
//   clk_i            : clock
//   reset_n_i        : asynchronous active-low reset
//   init_i           : load ctr_in_i into the counter (IDLE/READY only)
//   ctr_in_i         : initial counter block (nonce || counter)
//   data_in_i        : plaintext / ciphertext block
//   data_valid_i     : data_in_i valid
//   data_ready_o     : block can accept data_in_i
//   data_out_o       : data_in_i ^ E(counter), held until transferred
//   out_valid_o      : data_out_o valid
//   out_ready_i      : consumer accepts data_out_o
//   busy_o           : a block is in flight (START, WAIT, OUT)
//   wrap_err_o       : sticky counter-wrap flag
//   enc_next_o       : start pulse to the encipher stage
//   enc_block_o      : counter block to the encipher stage
//   enc_ready_i      : encipher stage ready
//   enc_new_block_i  : encipher stage result
// Configuration
//   AES_CTR_WRAP_ERR_EN : when defined, a counter wrap sets a sticky
//                         wrap_err_o that blocks new data until init/reset.
//                         When undefined, the counter wraps silently and
//                         wrap_err_o is tied low.
//=============================================================================
`default_nettype none

module aes_ctr_ctrl #(
  parameter int CTR_WIDTH = 32
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         init_i,
  input  logic [127:0] ctr_in_i,
  input  logic [127:0] data_in_i,
  input  logic         data_valid_i,
  output logic         data_ready_o,
  output logic [127:0] data_out_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         busy_o,
  output logic         wrap_err_o,
  output logic         enc_next_o,
  output logic [127:0] enc_block_o,
  input  logic         enc_ready_i,
  input  logic [127:0] enc_new_block_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t       state_q;
  logic [127:0] ctr_q;
  logic [127:0] ctr_d;
  logic [127:0] data_q;
  logic [127:0] data_out_q;
  logic         data_ready_q;
  logic         out_valid_q;
  logic         busy_q;
  logic         enc_next_q;
  logic         wrap_hold;

  // Counter increment: only the low CTR_WIDTH bits roll over, the nonce
  // above them is never touched.
  generate
    if (CTR_WIDTH >= 128) begin : g_full_ctr
      assign ctr_d = ctr_q + 128'd1;
    end else begin : g_part_ctr
      logic [CTR_WIDTH-1:0] low_inc;
      assign low_inc = ctr_q[CTR_WIDTH-1:0] + {{(CTR_WIDTH-1){1'b0}}, 1'b1};
      assign ctr_d   = {ctr_q[127:CTR_WIDTH], low_inc};
    end
  endgenerate

`ifdef AES_CTR_WRAP_ERR_EN
  logic wrap_err_q;
  logic wrap_d;

  // The increment about to happen wraps when the low field is all ones.
  assign wrap_d = &ctr_q[CTR_WIDTH-1:0];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wrap_err_q <= 1'b0;
    end else if (init_i && (state_q == S_IDLE || state_q == S_READY)) begin
      wrap_err_q <= 1'b0;
    end else if (state_q == S_WAIT && enc_ready_i && wrap_d) begin
      wrap_err_q <= 1'b1;
    end
  end

  assign wrap_hold  = wrap_err_q;
  assign wrap_err_o = wrap_err_q;
`else
  assign wrap_hold  = 1'b0;
  assign wrap_err_o = 1'b0;
`endif

  // Sequencer. All handshake outputs are registered and updated together
  // with the state so they always agree with it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      ctr_q        <= '0;
      data_q       <= '0;
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      enc_next_q   <= 1'b0;
    end else begin
      // The start pulse lasts exactly one cycle (the START state).
      enc_next_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (init_i) begin
            ctr_q        <= ctr_in_i;
            data_ready_q <= 1'b1;
            state_q      <= S_READY;
          end
        end
        S_READY: begin
          // init has priority over a simultaneous data beat; the reload
          // also clears any wrap error, so the block is ready again.
          if (init_i) begin
            ctr_q        <= ctr_in_i;
            data_ready_q <= 1'b1;
          end else if (data_valid_i && data_ready_q) begin
            data_q       <= data_in_i;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            enc_next_q   <= 1'b1;
            state_q      <= S_START;
          end
        end
        S_START: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // The encipher stage has already dropped ready when WAIT is
          // entered, so the first high level is the finished result.
          if (enc_ready_i) begin
            data_out_q  <= data_q ^ enc_new_block_i;
            ctr_q       <= ctr_d;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready_i) begin
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            data_ready_q <= ~wrap_hold;
            state_q      <= S_READY;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign data_ready_o = data_ready_q;
  assign data_out_o   = data_out_q;
  assign out_valid_o  = out_valid_q;
  assign busy_o       = busy_q;
  assign enc_next_o   = enc_next_q;
  assign enc_block_o  = ctr_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_ctr_ctrl.sv
//=============================================================================
// Module   : tb_aes_ctr_ctrl
// Purpose  : Self-checking bench for aes_ctr_ctrl. A behavioural encipher
//            stage returns a keystream block a programmable number of
//            cycles after each start pulse; expected results come from
//            the CTR rules (data ^ keystream, low-word increment).
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_aes_ctr_ctrl;

  localparam logic [127:0] NIST_CTR1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] NIST_CTR2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] NIST_PT1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] NIST_CT1  = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] NIST_PT2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] NIST_CT2  = 128'h9806f66b7970fdff8617187bb9fffdff;
  // AES-128 keystream blocks for the two NIST counters (E = PT ^ CT).
  localparam logic [127:0] NIST_KS1  = NIST_PT1 ^ NIST_CT1;
  localparam logic [127:0] NIST_KS2  = NIST_PT2 ^ NIST_CT2;

  logic         clk;
  logic         reset_n;
  logic         init;
  logic [127:0] ctr_in;
  logic [127:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic [127:0] data_out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         wrap_err;
  logic         enc_next;
  logic [127:0] enc_block;
  logic         enc_ready;
  logic [127:0] enc_new_block;

  int errors = 0;
  int checks = 0;
  int next_viol = 0;
  int enc_lat = 52;

  aes_ctr_ctrl #(.CTR_WIDTH(32)) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .init_i          (init),
    .ctr_in_i        (ctr_in),
    .data_in_i       (data_in),
    .data_valid_i    (data_valid),
    .data_ready_o    (data_ready),
    .data_out_o      (data_out),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .busy_o          (busy),
    .wrap_err_o      (wrap_err),
    .enc_next_o      (enc_next),
    .enc_block_o     (enc_block),
    .enc_ready_i     (enc_ready),
    .enc_new_block_i (enc_new_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keystream oracle: true AES-128 for the NIST counters, an arbitrary
  // deterministic scramble for everything else.
  function automatic logic [127:0] ks(input logic [127:0] c);
    logic [63:0] m;
    if (c == NIST_CTR1) return NIST_KS1;
    if (c == NIST_CTR2) return NIST_KS2;
    m = c[63:0] * 64'h9e3779b97f4a7c15;
    return {c[95:0], c[127:96]} ^ {m, m ^ c[127:64]} ^ 128'h5a5a_c3c3_0f0f_1234_abcd_9876_f00d_beef;
  endfunction

  // CTR rule: low 32 bits increment modulo 2^32, nonce unchanged.
  function automatic logic [127:0] next_ctr(input logic [127:0] c);
    logic [31:0] lo;
    lo = c[31:0] + 32'd1;
    return {c[127:32], lo};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Encipher stage model: samples next, drops ready on that edge and
  // raises it again enc_lat edges later with the keystream block.
  int           enc_cnt;
  logic         enc_busy;
  logic [127:0] enc_sample;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enc_ready     <= 1'b1;
      enc_busy      <= 1'b0;
      enc_cnt       <= 0;
      enc_sample    <= '0;
      enc_new_block <= '0;
    end else if (enc_next) begin
      enc_ready  <= 1'b0;
      enc_busy   <= 1'b1;
      enc_cnt    <= enc_lat;
      enc_sample <= enc_block;
    end else if (enc_busy) begin
      if (enc_cnt == 1) begin
        enc_ready     <= 1'b1;
        enc_busy      <= 1'b0;
        enc_new_block <= ks(enc_sample);
      end
      enc_cnt <= enc_cnt - 1;
    end
  end

  // Start-pulse protocol watcher: never two cycles in a row, never while
  // a block is still inside the encipher stage.
  logic prev_next = 1'b0;
  always @(posedge clk) begin
    if (reset_n) begin
      if (enc_next && (prev_next || enc_busy)) next_viol++;
      prev_next <= enc_next;
    end else begin
      prev_next <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [127:0] c);
    init   = 1'b1;
    ctr_in = c;
    tick();
    init   = 1'b0;
  endtask

  // Drives one block from READY through to the output transfer.
  task automatic run_block(input logic [127:0] d, input int lat, input int hold,
                           output logic [127:0] dout, output int cyc, output bit ok);
    enc_lat    = lat;
    ok         = 1'b1;
    cyc        = 0;
    dout       = '0;
    data_in    = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    while (!out_valid && cyc < lat + 40) begin
      tick();
      cyc++;
    end
    if (!out_valid) begin
      ok = 1'b0;
      return;
    end
    dout = data_out;
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({data_ready, out_valid, busy, enc_next, wrap_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {data_ready, out_valid, busy, enc_next, wrap_err});
    end
    checks++;
    if (data_out !== 128'h0 || enc_block !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: data_out=%h enc_block=%h expected zeros", data_out, enc_block);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (data_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_not_ready: data_ready=%b expected 0", data_ready);
    end
  endtask

  task automatic test_nist();
    logic [127:0] dout;
    int cyc;
    bit ok;
    do_init(NIST_CTR1);
    checks++;
    if (data_ready !== 1'b1 || enc_block !== NIST_CTR1) begin
      errors++;
      $display("FAIL nist_init: data_ready=%b enc_block=%h expected 1 %h", data_ready, enc_block, NIST_CTR1);
    end
    // Start pulse must appear in the cycle right after the accept edge.
    enc_lat    = 52;
    data_in    = NIST_PT1;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    checks++;
    if (enc_next !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL nist_start: enc_next=%b busy=%b expected 1 1", enc_next, busy);
    end
    cyc = 1;
    tick();
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 54) begin
      errors++;
      $display("FAIL nist_latency: out_valid at cycle %0d expected 54", cyc);
    end
    checks++;
    if (data_out !== NIST_CT1) begin
      errors++;
      $display("FAIL nist_block1: got %h expected %h", data_out, NIST_CT1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (enc_block !== NIST_CTR2) begin
      errors++;
      $display("FAIL nist_ctr2: got %h expected %h", enc_block, NIST_CTR2);
    end
    run_block(NIST_PT2, 52, 0, dout, cyc, ok);
    checks++;
    if (!ok || dout !== NIST_CT2) begin
      errors++;
      $display("FAIL nist_block2: got %h ok=%0d expected %h", dout, ok, NIST_CT2);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] c, d, snap;
    int cyc, bad;
    c = enc_block;
    d = rnd128();
    enc_lat    = $urandom_range(4, 15);
    data_in    = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    snap = data_out;
    checks++;
    if (!out_valid || snap !== (d ^ ks(c))) begin
      errors++;
      $display("FAIL bp_result: got %h valid=%b expected %h", snap, out_valid, d ^ ks(c));
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (data_out !== snap || out_valid !== 1'b1 || data_ready !== 1'b0 || enc_next !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles expected 0", bad);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (data_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: ready=%b valid=%b busy=%b expected 1 0 0", data_ready, out_valid, busy);
    end
  endtask

  task automatic test_random();
    logic [127:0] c, d, dout, exp;
    int lat, hold, cyc;
    bit ok;
    c = rnd128();
    c[31:28] = 4'h0;
    do_init(c);
    for (int i = 0; i < 16; i++) begin
      d    = rnd128();
      lat  = $urandom_range(2, 12);
      hold = $urandom_range(0, 3);
      exp  = d ^ ks(c);
      checks++;
      if (enc_block !== c) begin
        errors++;
        $display("FAIL rnd_ctr[%0d]: got %h expected %h", i, enc_block, c);
      end
      run_block(d, lat, hold, dout, cyc, ok);
      checks++;
      if (!ok || dout !== exp) begin
        errors++;
        $display("FAIL rnd_data[%0d]: got %h ok=%0d expected %h", i, dout, ok, exp);
      end
      checks++;
      if (cyc !== lat + 2) begin
        errors++;
        $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, cyc, lat + 2);
      end
      c = next_ctr(c);
    end
  endtask

  task automatic test_init_wait();
    logic [127:0] c, d;
    int cyc;
    c = rnd128();
    c[31:28] = 4'h0;
    d = rnd128();
    do_init(c);
    enc_lat    = 20;
    data_in    = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (5) tick();
    init   = 1'b1;
    ctr_in = ~c;
    tick();
    init   = 1'b0;
    checks++;
    if (busy !== 1'b1 || enc_block !== c) begin
      errors++;
      $display("FAIL initwait_ignored: busy=%b enc_block=%h expected 1 %h", busy, enc_block, c);
    end
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    checks++;
    if (!out_valid || data_out !== (d ^ ks(c))) begin
      errors++;
      $display("FAIL initwait_data: got %h expected %h", data_out, d ^ ks(c));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (enc_block !== next_ctr(c)) begin
      errors++;
      $display("FAIL initwait_ctr: got %h expected %h", enc_block, next_ctr(c));
    end
  endtask

  task automatic test_init_data();
    logic [127:0] y;
    y = rnd128();
    y[31:28] = 4'h0;
    init       = 1'b1;
    ctr_in     = y;
    data_valid = 1'b1;
    data_in    = rnd128();
    tick();
    init       = 1'b0;
    data_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || enc_block !== y || data_ready !== 1'b1) begin
      errors++;
      $display("FAIL initdata: busy=%b enc_block=%h ready=%b expected 0 %h 1", busy, enc_block, data_ready, y);
    end
    tick();
    checks++;
    if (enc_next !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL initdata_nostart: enc_next=%b busy=%b expected 0 0", enc_next, busy);
    end
  endtask

  task automatic test_wrap();
    logic [127:0] c, d, dout;
    int cyc;
    bit ok;
    c = rnd128();
    c[31:0] = 32'hffffffff;
    d = rnd128();
    do_init(c);
    run_block(d, 6, 0, dout, cyc, ok);
    checks++;
    if (!ok || dout !== (d ^ ks(c))) begin
      errors++;
      $display("FAIL wrap_data: got %h expected %h", dout, d ^ ks(c));
    end
    checks++;
    if (enc_block !== {c[127:32], 32'h0}) begin
      errors++;
      $display("FAIL wrap_ctr: got %h expected %h", enc_block, {c[127:32], 32'h0});
    end
`ifdef AES_CTR_WRAP_ERR_EN
    checks++;
    if (wrap_err !== 1'b1 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL wrap_flag: wrap_err=%b ready=%b expected 1 0", wrap_err, data_ready);
    end
    data_in    = rnd128();
    data_valid = 1'b1;
    repeat (3) tick();
    data_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || wrap_err !== 1'b1) begin
      errors++;
      $display("FAIL wrap_blocked: busy=%b wrap_err=%b expected 0 1", busy, wrap_err);
    end
    c[31:0] = 32'h00000010;
    do_init(c);
    checks++;
    if (wrap_err !== 1'b0 || data_ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_clear: wrap_err=%b ready=%b expected 0 1", wrap_err, data_ready);
    end
`else
    checks++;
    if (wrap_err !== 1'b0 || data_ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_silent: wrap_err=%b ready=%b expected 0 1", wrap_err, data_ready);
    end
    c = {c[127:32], 32'h0};
    d = rnd128();
    run_block(d, 5, 1, dout, cyc, ok);
    checks++;
    if (!ok || dout !== (d ^ ks(c))) begin
      errors++;
      $display("FAIL wrap_continue: got %h expected %h", dout, d ^ ks(c));
    end
`endif
  endtask

  task automatic test_reset_wait();
    logic [127:0] c;
    c = rnd128();
    c[31:28] = 4'h0;
    do_init(c);
    enc_lat    = 30;
    data_in    = rnd128();
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (5) tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({data_ready, out_valid, busy, enc_next, wrap_err} !== 5'b0 || data_out !== 128'h0 || enc_block !== 128'h0) begin
      errors++;
      $display("FAIL rstwait_async: flags=%b data_out=%h enc_block=%h expected zeros",
               {data_ready, out_valid, busy, enc_next, wrap_err}, data_out, enc_block);
    end
    tick();
    reset_n    = 1'b1;
    data_valid = 1'b1;
    repeat (3) tick();
    data_valid = 1'b0;
    checks++;
    if (data_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_idle: ready=%b busy=%b valid=%b expected 0 0 0", data_ready, busy, out_valid);
    end
    do_init(c);
    checks++;
    if (data_ready !== 1'b1 || enc_block !== c) begin
      errors++;
      $display("FAIL rstwait_reinit: ready=%b enc_block=%h expected 1 %h", data_ready, enc_block, c);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (next_viol !== 0) begin
      errors++;
      $display("FAIL enc_next_protocol: %0d violations expected 0", next_viol);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    init       = 1'b0;
    ctr_in     = '0;
    data_in    = '0;
    data_valid = 1'b0;
    out_ready  = 1'b0;
    test_reset();
    test_nist();
    test_backpressure();
    test_random();
    test_init_wait();
    test_init_data();
    test_wrap();
    test_reset_wait();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_ctr_ctrl.md
# aes_ctr_ctrl

Counter-mode (CTR) sequencer that sits directly upstream of the AES encipher round stage. It owns the 128-bit counter block and drives it into the encipher stage with a one-cycle `next` pulse. It captures the enciphered block when the stage reports ready, XORs it with the accepted data word, and presents the result on a valid/ready output. Key expansion and keylen selection are handled outside this block; the encipher stage is used strictly one block at a time.

## Interface
- `CTR_WIDTH`, default 32: number of low counter bits that increment; upper `128-CTR_WIDTH` bits are a fixed nonce. Legal range 8..128.
- `clk` input 1: clock.
- `reset_n` input 1: reset, asynchronous, active-low.
- `init` input 1: load `ctr_in` into the counter (one-cycle strobe).
- `ctr_in` input 128: initial counter block (nonce || counter).
- `data_in` input 128: plaintext or ciphertext block.
- `data_valid` input 1: `data_in` valid.
- `data_ready` output 1: block can accept `data_in`.
- `data_out` output 128: `data_in ^ E(counter)`.
- `out_valid` output 1: `data_out` valid.
- `out_ready` input 1: consumer accepts `data_out`.
- `busy` output 1: a block is in flight (states START, WAIT, OUT).
- `wrap_err` output 1: sticky counter-wrap flag (see Configuration).
- `enc_next` output 1: start pulse to the encipher stage.
- `enc_block` output 128: counter block to the encipher stage; always equals the counter register.
- `enc_ready` input 1: encipher stage ready.
- `enc_new_block` input 128: encipher stage result.

## Operation
- Reset values:
  - `data_ready`, `out_valid`, `busy`, `enc_next`, `wrap_err` are 0.
  - `data_out` and the counter register (`enc_block`) are 0.
  - The FSM is in IDLE.
- FSM states: IDLE, READY, START, WAIT, OUT.
- IDLE: no counter loaded. `init` loads `ctr_in` and moves to READY.
- READY:
  - `data_ready=1` unless `wrap_err`.
  - `init` reloads the counter, clears `wrap_err` and stays in READY. If `init` and `data_valid` occur together, `init` wins and data is not accepted.
  - `data_valid && data_ready` latches `data_in` and moves to START.
- START: `enc_next=1` for exactly this cycle, then WAIT.
- WAIT:
  - `enc_ready` is already 0 on entry, because the encipher stage drops ready the edge after it samples `next`.
  - When `enc_ready=1`:
    - register `data_out = data_reg ^ enc_new_block`;
    - increment the counter: low `CTR_WIDTH` bits mod 2^CTR_WIDTH, upper bits unchanged;
    - move to OUT.
- OUT:
  - `out_valid=1`; `data_out` is held stable until `out_ready`.
  - On transfer, move to READY.
- `init` in START, WAIT or OUT is ignored.
- Wrap: a wrap occurs when the incremented low field was all ones. Behaviour depends on the Configuration macro.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight encipher result is discarded; the encipher stage is reset by the same `reset_n`.

## Timing
- Accept data at cycle 0, `enc_next` at cycle 1, encipher INIT at cycle 2.
- Each encipher round is 5 cycles (4 SBOX + 1 MAIN/FINAL).
- AES-128: `enc_ready` rises at cycle 53; `out_valid` is high from cycle 54.
- AES-256: `enc_ready` rises at cycle 73; `out_valid` is high from cycle 74.
- General latency: encipher latency + 2 cycles from accept to `out_valid`.
- The earliest next accept is the cycle after the output transfer. Throughput is one block per (latency + 2) cycles with `out_ready` tied high.
- `enc_next` is never asserted while the FSM is outside START, and never for more than one cycle.

## Configuration
- Macro: `AES_CTR_WRAP_ERR_EN`.
- Defined:
  - a wrap sets `wrap_err`, which is sticky;
  - `data_ready` is held 0 while `wrap_err` is set;
  - only `init` or reset clears it.
- Not defined:
  - the counter wraps silently and operation continues;
  - `wrap_err` is tied to 0.

## Test plan
- NIST SP800-38A CTR-AES128 block 1:
  - setup: key 2b7e151628aed2a6abf7158809cf4f3c, `init` with `ctr_in`=f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  - stimulus: `data_in`=6bc1bee22e409f96e93d7e117393172a;
  - required: `data_out`=874d6191b620e3261bef6864990db6ce, `out_valid` at cycle 54.
- Block 2 follows without re-init:
  - required: `enc_block`=f0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  - stimulus: `data_in`=ae2d8a571e03ac9c9eb76fac45af8e51;
  - required: `data_out`=9806f66b7970fdff8617187bb9fffdff.
- Backpressure:
  - stimulus: hold `out_ready=0` for 20 cycles after `out_valid`;
  - required: `data_out` stable, `data_ready=0`, no second `enc_next`;
  - required after release: READY the next cycle.
- Wrap with `CTR_WIDTH`=32:
  - stimulus: `ctr_in`=…_ffffffff, one block processed;
  - required: `enc_block` low word 00000000, upper 96 bits unchanged;
  - with macro: `wrap_err=1`, `data_ready=0` until `init`;
  - without macro: `wrap_err=0`, next block accepted.
- `init` during WAIT:
  - required: ignored, and the counter still increments from the original value.
- `init` together with `data_valid` in READY:
  - required: counter reloaded, data not accepted.
- `reset_n` low in WAIT:
  - required: all outputs return to reset values that cycle;
  - required: after reset, `data_ready=0` until `init`.
